// File: rtl/bb_game_scheduler.sv
// -----------------------------------------------------------------------------
// bb_game_scheduler
//
// Front end for the baseball scoring core (BB). It collects one game's worth
// of batting actions from an upstream requester and stamps each action with
// the inning/half that is current when it arrives. It then replays the whole
// game to BB as one gap-free in_valid burst, waits for BB's single-cycle
// result and holds that result for a downstream consumer under valid/ready.
//
// Parameters
//   DEPTH    action buffer entries (power of 2, >= 8); maximum actions per game
//   TIMEOUT  cycles to wait for bb_out_valid after the burst before aborting
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   req_valid/ready     upstream action handshake
//   req_action          BB action code, forwarded unchanged
//   req_half_end        action closes the current half-inning
//   req_game_end        action closes the game
//   bb_in_valid         burst strobe to BB
//   bb_inning/half      stamp of the issued action (inning 1..3, 0 = top)
//   bb_action           issued action code
//   bb_out_valid        BB result strobe (only honoured while waiting)
//   bb_score_A/B        BB scores
//   bb_result           BB result code
//   res_valid/ready     downstream result handshake
//   res_score_A/B       captured scores (0 on timeout)
//   res_result          captured result (2'b11 on timeout)
//   err                 sticky: forced game end or BB timeout; cleared by rst
//   busy                high whenever the scheduler is not loading
// -----------------------------------------------------------------------------
module bb_game_scheduler #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_action,
    input  logic       req_half_end,
    input  logic       req_game_end,

    output logic       bb_in_valid,
    output logic [1:0] bb_inning,
    output logic       bb_half,
    output logic [2:0] bb_action,
    input  logic       bb_out_valid,
    input  logic [7:0] bb_score_A,
    input  logic [7:0] bb_score_B,
    input  logic [1:0] bb_result,

    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_score_A,
    output logic [7:0] res_score_B,
    output logic [1:0] res_result,

    output logic       err,
    output logic       busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StLoad,
        StIssue,
        StWait,
        StReport
    } state_e;

    state_e state;

    // Entry layout: {action[2:0], inning[1:0], half}
    logic [5:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;     // entries stored for this game
    logic [CW-1:0] issued;    // entries already driven to BB
    logic [1:0]    inning;
    logic          half;
    logic [TW-1:0] wait_cnt;

    logic          accept;
    logic          past_last_half;
    logic          fills_buffer;
    logic          end_game;
    logic [5:0]    new_entry;
    logic [5:0]    rd_entry;

    assign accept         = (state == StLoad) && req_valid && req_ready;
    // A half_end on inning 3 bottom has nowhere to go, so the game is closed.
    assign past_last_half = req_half_end && (inning == 2'd3) && half && !req_game_end;
    assign fills_buffer   = (count == CW'(DEPTH - 1)) && !req_game_end;
    assign end_game       = req_game_end || past_last_half || fills_buffer;
    assign new_entry      = {req_action, inning, half};
    assign rd_entry       = mem[rd_ptr];

    // Storage has no reset; validity is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StLoad;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            issued      <= '0;
            inning      <= 2'd1;
            half        <= 1'b0;
            wait_cnt    <= '0;
            req_ready   <= 1'b1;
            bb_in_valid <= 1'b0;
            bb_inning   <= 2'd0;
            bb_half     <= 1'b0;
            bb_action   <= 3'd0;
            res_valid   <= 1'b0;
            res_score_A <= 8'd0;
            res_score_B <= 8'd0;
            res_result  <= 2'd0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                StLoad: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        count  <= count + 1'b1;
                        if (end_game) begin
                            if (!req_game_end) begin
                                err <= 1'b1;
                            end
                            req_ready   <= 1'b0;
                            busy        <= 1'b1;
                            state       <= StIssue;
                            // The first entry goes out on the accepting edge; for a
                            // one-action game it is the entry being written now.
                            bb_in_valid <= 1'b1;
                            {bb_action, bb_inning, bb_half} <=
                                (count == '0) ? new_entry : rd_entry;
                            rd_ptr      <= rd_ptr + 1'b1;
                            issued      <= CW'(1);
                        end else if (req_half_end) begin
                            if (half) begin
                                half   <= 1'b0;
                                inning <= inning + 2'd1;
                            end else begin
                                half   <= 1'b1;
                            end
                        end
                    end
                end

                StIssue: begin
                    if (issued == count) begin
                        bb_in_valid <= 1'b0;
                        bb_inning   <= 2'd0;
                        bb_half     <= 1'b0;
                        bb_action   <= 3'd0;
                        wait_cnt    <= '0;
                        state       <= StWait;
                    end else begin
                        bb_in_valid <= 1'b1;
                        {bb_action, bb_inning, bb_half} <= rd_entry;
                        rd_ptr      <= rd_ptr + 1'b1;
                        issued      <= issued + 1'b1;
                    end
                end

                StWait: begin
                    if (bb_out_valid) begin
                        res_score_A <= bb_score_A;
                        res_score_B <= bb_score_B;
                        res_result  <= bb_result;
                        res_valid   <= 1'b1;
                        state       <= StReport;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        res_score_A <= 8'd0;
                        res_score_B <= 8'd0;
                        res_result  <= 2'b11;
                        res_valid   <= 1'b1;
                        err         <= 1'b1;
                        state       <= StReport;
                    end else begin
                        wait_cnt    <= wait_cnt + 1'b1;
                    end
                end

                StReport: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        count     <= '0;
                        issued    <= '0;
                        inning    <= 2'd1;
                        half      <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StLoad;
                    end
                end

                default: begin
                    state <= StLoad;
                end
            endcase
        end
    end

endmodule

// File: doc/bb_game_scheduler.md
# bb_game_scheduler

Front-end scheduler for the baseball scoring core (BB). Accepts a per-game stream of batting actions from an upstream requester, buffers the whole game, and stamps each action with its inning and half. It replays the game to BB as one contiguous in_valid burst, then captures BB's single-cycle result and holds it for a downstream consumer under a valid/ready handshake.

## Interface
- DEPTH, 32: action buffer entries (power of 2, ≥ 8); maximum actions per game.
- TIMEOUT, 1023: cycles to wait for bb_out_valid after the burst before aborting.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  action offered.
- req_ready  out  1  scheduler can accept.
- req_action  in  3  BB action code, forwarded unchanged.
- req_half_end  in  1  this action ends the current half-inning.
- req_game_end  in  1  this action ends the game.
- bb_in_valid  out  1  BB in_valid.
- bb_inning  out  2  BB inning, 1..3.
- bb_half  out  1  BB half: 0 = top, 1 = bottom.
- bb_action  out  3  BB action.
- bb_out_valid  in  1  BB result strobe.
- bb_score_A, bb_score_B  in  8 each  BB scores.
- bb_result  in  2  BB result code.
- res_valid  out  1  captured result available.
- res_ready  in  1  consumer accepts.
- res_score_A, res_score_B  out  8 each  captured scores.
- res_result  out  2  captured result; 2'b11 on timeout.
- err  out  1  sticky error flag; cleared only by rst.
- busy  out  1  high in every state other than LOAD.

## Operation
- FSM states: LOAD → ISSUE → WAIT → REPORT → LOAD.
- LOAD:
  - req_ready = 1.
  - An entry is accepted on a clock edge where req_valid and req_ready are both high.
  - Each accepted entry stores {action, inning, half} using the current stamp.
  - The stamp starts at inning 1, half 0.
  - On an accepted half_end entry: if half = 0, set half = 1. Otherwise set half = 0 and increment inning.
- Forced end-of-game: an accepted entry is treated as game_end, and err is set, when either:
  - it would advance past inning 3 bottom (half_end on inning 3 bottom without game_end), or
  - it fills the buffer (count becomes DEPTH) without game_end.
- Accepting a game_end entry moves the FSM to ISSUE. req_ready drops on the following cycle.
- ISSUE:
  - Reads one entry per cycle in FIFO order and drives bb_in_valid with that entry's fields.
  - Exactly N consecutive cycles, where N = entries stored for the game.
  - No gaps in the burst.
  - After the last entry, go to WAIT.
- WAIT:
  - Cycle counter starts at 0.
  - When bb_out_valid = 1, capture score_A, score_B and result, then go to REPORT.
  - If the counter reaches TIMEOUT first: capture scores 0 and result 2'b11, set err, go to REPORT.
- REPORT:
  - res_valid = 1 and res_* stay stable until res_ready is high at a clock edge.
  - Then clear the buffer pointers, reset the stamp to inning 1 top, and return to LOAD.
- bb_out_valid outside WAIT is ignored.
- Buffer: circular, with wrapping read and write pointers. The pointers are cleared at each game start, so one game never shares the buffer with another.

## Timing
- Reset values:
  - req_ready = 1; all other outputs 0 (bb_in_valid, bb_inning, bb_half, bb_action, res_valid, res_score_A, res_score_B, res_result, err, busy).
  - FSM = LOAD; stamp = inning 1 top; buffer empty.
- Reset asserted mid-game: outputs take their reset values immediately (asynchronously) and the buffered game is discarded.
- All outputs are registered.
- bb_inning, bb_half and bb_action are 0 whenever bb_in_valid = 0.
- Game_end accepted at edge k:
  - bb_in_valid is high on edges k+1 through k+N.
  - bb_in_valid is low at edge k+N+1.
- bb_out_valid sampled high at edge m: res_valid is high from edge m+1.
- res handshake completes at edge r: res_valid = 0 and req_ready = 1 from edge r+1.
- Timeout: detected TIMEOUT cycles after WAIT entry; res_valid rises one cycle later.
- Single-action game (game_end on the first action): N = 1, a one-cycle burst.

## Test plan
- Six actions, half_end on entries 2 and 4, game_end on entry 6 → one 6-cycle burst stamped (1,0), (1,0), (1,1), (1,1), (2,0), (2,0). BB returns A=3, B=1, result=0 → res_* equal 3/1/0.
- Upstream toggles req_valid every other cycle → the burst is still contiguous, with identical stamps and actions.
- Three actions with half_end on all of them, so the stamp reaches inning 2 bottom, then game_end → last entry stamped (2,1); err = 0.
- DEPTH actions with no game_end → req_ready low after entry DEPTH; burst of DEPTH cycles; err = 1.
- BB never asserts out_valid → after TIMEOUT cycles, res_result = 2'b11, scores 0, err = 1.
- rst pulsed during ISSUE → bb_in_valid = 0 immediately; the next game starts at inning 1 top with an empty buffer.
